// File: rtl/grant_arbiter_pkg.sv
// Shared types for the round-robin grant arbiter.
package grant_arbiter_pkg;

   // Arbiter FSM states; encoding is visible on o_state.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUESTING = 2'd1,
      GRANT      = 2'd2,
      REVOKE     = 2'd3
   } ty_STATE_FSM;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner selection.
// Searches upward from (i_ptr + 1) mod N_CH with wrap-around; the first
// requesting channel found wins. o_valid is low when no channel requests.
module rr_arbiter_pick #(
   parameter  int unsigned N_CH  = 4,
   localparam int unsigned IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   logic [IDX_W-1:0] cand_idx;

   // Scan all channels starting just after the pointer; keep the first hit.
   always_comb begin
      o_idx    = '0;
      o_valid  = 1'b0;
      cand_idx = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand_idx = IDX_W'((32'(i_ptr) + k) % N_CH);
         if (!o_valid && i_req[cand_idx]) begin
            o_valid = 1'b1;
            o_idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/grant_arbiter_fsm.sv
// Round-robin grant arbiter with voluntary release and revoke handshake.
// Optional feature: define GRANT_TIMEOUT_EN to force a revoke after
// HOLD_CYCLES cycles of uninterrupted GRANT residency.
module grant_arbiter_fsm
   import grant_arbiter_pkg::*;
#(
   parameter  int unsigned N_CH        = 4,
   parameter  int unsigned HOLD_CYCLES = 16,
   localparam int unsigned IDX_W       = $clog2(N_CH)
) (
   input  logic             i_ck,
   input  logic             i_arstn,
   input  logic [N_CH-1:0]  i_req,
   input  logic [N_CH-1:0]  i_release,
   input  logic             i_revokeReq,
   input  logic [N_CH-1:0]  i_revokeAck,
   output logic [N_CH-1:0]  o_grant,
   output logic [N_CH-1:0]  o_revoke,
   output logic [IDX_W-1:0] o_grantIdx,
   output logic [1:0]       o_state,
   output logic             o_timeout
);

   ty_STATE_FSM      state_q, state_d;
   logic [IDX_W-1:0] holder_q, holder_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [N_CH-1:0]  grant_q, grant_d;
   logic [N_CH-1:0]  revoke_q, revoke_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic             timeout_q, timeout_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic             timeout_hit;
   logic             granting;

   rr_arbiter_pick #(
      .N_CH (N_CH)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (rr_q),
      .o_idx   (pick_idx),
      .o_valid (pick_valid)
   );

`ifdef GRANT_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   // Counter value equals completed GRANT cycles, so this fires on the last allowed one.
   assign timeout_hit = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

   // Residency counter: cleared on the way into GRANT, counts each GRANT cycle.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_q == REQUESTING) begin
         hold_cnt_d = '0;
      end else if (state_q == GRANT) begin
         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_hold_cycles;

   assign unused_hold_cycles = ^HOLD_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   // Next-state logic; outputs are derived from the next state so they register with it.
   always_comb begin
      state_d   = state_q;
      holder_d  = holder_q;
      rr_d      = rr_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|i_req) begin
               state_d = REQUESTING;
            end
         end
         REQUESTING: begin
            if (pick_valid) begin
               holder_d = pick_idx;
               state_d  = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            // Release (or dropped request) beats revoke in the same cycle.
            if (i_release[holder_q] || !i_req[holder_q]) begin
               state_d = IDLE;
               rr_d    = holder_q;
            end else if (i_revokeReq || timeout_hit) begin
               state_d   = REVOKE;
               timeout_d = timeout_hit;
            end
         end
         REVOKE: begin
            if (i_revokeAck[holder_q] || i_release[holder_q]) begin
               state_d = IDLE;
               rr_d    = holder_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      granting    = (state_d == GRANT) || (state_d == REVOKE);
      grant_d     = granting ? (N_CH'(1) << holder_d) : '0;
      revoke_d    = (state_d == REVOKE) ? (N_CH'(1) << holder_d) : '0;
      grant_idx_d = granting ? holder_d : '0;
   end

   // All state and registered outputs; reset drops grant/revoke asynchronously.
   always_ff @(posedge i_ck or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q     <= IDLE;
         holder_q    <= '0;
         rr_q        <= IDX_W'(N_CH - 1);
         grant_q     <= '0;
         revoke_q    <= '0;
         grant_idx_q <= '0;
         timeout_q   <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
         hold_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         holder_q    <= holder_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         revoke_q    <= revoke_d;
         grant_idx_q <= grant_idx_d;
         timeout_q   <= timeout_d;
`ifdef GRANT_TIMEOUT_EN
         hold_cnt_q  <= hold_cnt_d;
`endif
      end
   end

   assign o_grant    = grant_q;
   assign o_revoke   = revoke_q;
   assign o_grantIdx = grant_idx_q;
   assign o_state    = state_q;
   assign o_timeout  = timeout_q;

endmodule
